rx_readout_sched: RTL and testbench
===================================

# rx_readout_sched

Per-sample readout scheduler for the bank of `rx_wb` receiver channels, in the ADC clock domain. On each decimated-output strobe it walks every channel in turn, drives the channel select and the I/Q/packed-MSB read strobes, and writes the three returned 16-bit words into the double-buffered sample RAM. It counts samples per buffer half, tells the CPU when a half is full, and flags overruns. In wideband mode it is paced by the first-stage CIC strobe and reads the wideband word layout.

## Interface
- `NRX`, 4: number of receiver channels scanned; 1..12.
- `NSAMPS`, 256: samples per channel per buffer half.
- `ADDR_W`, 13: sample-RAM word-address width; must satisfy 2^ADDR_W ≥ 2·HALF_WORDS.
- `adc_clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `rx_avail_A`  in  1  one-cycle strobe; all channels' final decimated outputs are valid.
- `rx_avail_wb_A`  in  1  one-cycle strobe; first-stage CIC outputs are valid (wideband pacing).
- `wb_en`  in  1  wideband mode select; sampled only in IDLE.
- `rx_din`  in  16  read data from the selected channel's output mux, valid combinationally in the same cycle as the strobes.
- `rxn_o`  out  4  channel select.
- `rd_getI`, `rd_getQ`, `rd_getWB`  out  1 each  read strobes to the channel mux.
- `wr_en`  out  1  sample-RAM write enable.
- `waddr_o`  out  ADDR_W  write address.
- `wdata_o`  out  16  write data.
- `count_o`  out  16  samples completed in the current half.
- `buf_half_o`  out  1  half currently being filled.
- `buf_ready`  out  1  one-cycle pulse when a half has been completed.
- `overrun`  out  1  sticky; a strobe arrived while the scheduler was busy.
- `overrun_clr`  in  1  clears `overrun`.

## Operation
- HALF_WORDS = 3·NRX·NSAMPS, plus 3 when `RX_SCHED_TICKS_EN` is defined.
- **FSM states:**
  - IDLE: a pacing strobe moves the FSM to RD_I(ch=0). The pacing strobe is `rx_avail_A` when `wb_en`=0, or `rx_avail_wb_A` when `wb_en`=1.
  - Per channel: RD_I → RD_Q → RD_P. RD_P is the packed word, with both getI and getQ low.
  - After RD_P: if ch < NRX−1, go to RD_I with ch+1; otherwise go to DONE.
  - DONE → IDLE.
- `rd_getWB` equals the latched `wb_en` for the whole sequence. `rxn_o` = ch.
- Each read cycle captures `rx_din` into `wdata_o`. The address is base(half) + offset, where base = `buf_half_o`·HALF_WORDS; `waddr_o` and `wr_en` are registered together with `wdata_o`.
- Word order per sample: ch0 I, Q, P, then ch1 I, Q, P, and so on.
- In DONE, `count_o` increments. If it reaches NSAMPS:
  - `count_o` returns to 0;
  - the offset returns to 0;
  - `buf_half_o` toggles;
  - `buf_ready` pulses.
- **Overrun:** a pacing strobe seen in any state other than IDLE is dropped and sets `overrun`. If set and `overrun_clr` occur in the same cycle, set wins.
- A strobe in the same cycle as the DONE→IDLE transition counts as busy, so it is dropped and flags an overrun.
- The `wb_en` value seen on the cycle a sequence starts is held for that sequence; a change mid-sequence has no effect until IDLE.
- **Reset:** every output goes to 0 (`rxn_o`, strobes, `wr_en`, `waddr_o`, `wdata_o`, `count_o`, `buf_half_o`, `buf_ready`, `overrun`) and the FSM returns to IDLE.
  - A reset mid-sequence aborts the sequence: no further writes, and the partial sample is discarded.

## Timing
- Strobe at cycle t:
  - `rd_get*`/`rxn_o` are registered and active t+1 … t+3·NRX.
  - `wr_en` is high t+2 … t+3·NRX+1, with contiguous addresses.
  - DONE is at t+3·NRX+1; `count_o` updates at t+3·NRX+2.
  - `buf_ready` is at t+3·NRX+2, together with the `buf_half_o` toggle.
- Minimum strobe spacing without overrun: 3·NRX+2 cycles.
- `wr_en` is never high in IDLE. It is never high for more than 3·NRX (+3 with ticks) consecutive cycles.

## Configuration
- **`RX_SCHED_TICKS_EN` defined:**
  - A 48-bit free-running `adc_clk` tick counter exists; it is reset to 0 by `reset`.
  - On the first sequence of each half (count 0), the state TICKS precedes RD_I(ch=0).
  - TICKS writes 3 words: counter[15:0], [31:16], [47:32]. The value is latched on the strobe cycle.
  - Latency and minimum spacing grow by 3 cycles on those sequences only.
- **Not defined:** no counter, no TICKS state, and HALF_WORDS = 3·NRX·NSAMPS.

## Test plan
- **Basic sequence.** NRX=4, `wb_en`=0, single `rx_avail_A` at t=10, `rx_din` = 16'h1000 + cycle index.
  - Expect 12 writes at t=12..23, addresses 0..11, `rxn_o` 0,0,0,1,1,1,…
  - Expect `count_o`=1 at t=24.
- **Buffer swap.** NSAMPS=2, 2 strobes spaced 20 cycles.
  - Expect `buf_ready` pulse, `buf_half_o` 0→1, and `count_o` back to 0.
  - The third strobe's first write lands at address 24.
- **Overrun.** Second `rx_avail_A` 5 cycles after the first.
  - Expect `overrun`=1, only 12 writes, and `count_o`=1.
  - Assert `overrun_clr` together with a new busy strobe: `overrun` stays 1.
- **Wideband mode.** `wb_en`=1.
  - `rx_avail_A` pulses are ignored; `rx_avail_wb_A` starts a sequence with `rd_getWB`=1 throughout.
  - Toggling `wb_en` mid-sequence leaves `rd_getWB` unchanged.
- **Reset mid-sequence.** Assert `reset` at the 5th read cycle.
  - All outputs are 0 the next cycle, with no further `wr_en`.
  - A fresh strobe restarts at address 0, ch 0.
- **Ticks (`RX_SCHED_TICKS_EN`).** Strobe at tick 100.
  - The first 3 writes are 100, 0, 0; samples follow at address 3.
  - The second sample of the same half has no tick words.

Source files
------------

// File: rtl/rx_readout_sched_if.sv
// rtl/rx_readout_sched_if.sv - channel-read and sample-RAM write bus of the readout scheduler
`timescale 1ns/1ps
interface rx_readout_sched_if #(parameter int ADDR_W = 13);
  logic [3:0]        rxn_o;
  logic              rd_getI;
  logic              rd_getQ;
  logic              rd_getWB;
  logic [15:0]       rx_din;
  logic              wr_en;
  logic [ADDR_W-1:0] waddr_o;
  logic [15:0]       wdata_o;

  modport master (
    output rxn_o, rd_getI, rd_getQ, rd_getWB, wr_en, waddr_o, wdata_o,
    input  rx_din
  );
  modport slave (
    input  rxn_o, rd_getI, rd_getQ, rd_getWB, wr_en, waddr_o, wdata_o,
    output rx_din
  );
endinterface

// File: rtl/rx_readout_sched.sv
// rtl/rx_readout_sched.sv - per-sample receiver readout scheduler into the double-buffered sample RAM
// Optional timestamp words per buffer half: define RX_SCHED_TICKS_EN.
`timescale 1ns/1ps
module rx_readout_sched #(
  parameter int NRX    = 4,
  parameter int NSAMPS = 256,
  parameter int ADDR_W = 13
) (
  input  logic               adc_clk,
  input  logic               reset,
  input  logic               rx_avail_A,
  input  logic               rx_avail_wb_A,
  input  logic               wb_en,
  input  logic               overrun_clr,
  rx_readout_sched_if.master bus,
  output logic [15:0]        count_o,
  output logic               buf_half_o,
  output logic               buf_ready,
  output logic               overrun
);
`ifdef RX_SCHED_TICKS_EN
  localparam int TICK_WORDS = 3;
`else
  localparam int TICK_WORDS = 0;
`endif
  localparam int HALF_WORDS = 3 * NRX * NSAMPS + TICK_WORDS;

  typedef enum logic [2:0] {IDLE, TICKS, RD_I, RD_Q, RD_P, DONE} state_t;

  state_t            state;
  logic [3:0]        ch;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] base;
  logic [15:0]       wsrc;
  logic              pace;
  logic              reading;

  assign pace    = wb_en ? rx_avail_wb_A : rx_avail_A;
  assign base    = buf_half_o ? ADDR_W'(HALF_WORDS) : '0;
  assign reading = (state == TICKS) || (state == RD_I) || (state == RD_Q) || (state == RD_P);

`ifdef RX_SCHED_TICKS_EN
  logic [47:0] tick_cnt;
  logic [47:0] tick_lat;
  logic [1:0]  tidx;
  logic [15:0] tick_word;

  always_ff @(posedge adc_clk) begin
    if (reset) tick_cnt <= '0;
    else       tick_cnt <= tick_cnt + 48'd1;
  end

  always_comb begin
    case (tidx)
      2'd0:    tick_word = tick_lat[15:0];
      2'd1:    tick_word = tick_lat[31:16];
      default: tick_word = tick_lat[47:32];
    endcase
  end

  assign wsrc = (state == TICKS) ? tick_word : bus.rx_din;
`else
  assign wsrc = bus.rx_din;
`endif

  always_ff @(posedge adc_clk) begin
    if (reset) begin
      state        <= IDLE;
      ch           <= '0;
      offset       <= '0;
      bus.rxn_o    <= '0;
      bus.rd_getI  <= 1'b0;
      bus.rd_getQ  <= 1'b0;
      bus.rd_getWB <= 1'b0;
      bus.wr_en    <= 1'b0;
      bus.waddr_o  <= '0;
      bus.wdata_o  <= '0;
      count_o      <= '0;
      buf_half_o   <= 1'b0;
      buf_ready    <= 1'b0;
      overrun      <= 1'b0;
`ifdef RX_SCHED_TICKS_EN
      tick_lat     <= '0;
      tidx         <= '0;
`endif
    end else begin
      bus.wr_en <= 1'b0;
      buf_ready <= 1'b0;

      // The DONE cycle counts as busy, so only IDLE accepts a strobe.
      if (pace && state != IDLE) overrun <= 1'b1;
      else if (overrun_clr)      overrun <= 1'b0;

      if (reading) begin
        bus.wr_en   <= 1'b1;
        bus.wdata_o <= wsrc;
        bus.waddr_o <= base + offset;
        offset      <= offset + 1'b1;
      end

      case (state)
        IDLE: if (pace) begin
          bus.rd_getWB <= wb_en;
          bus.rxn_o    <= '0;
          ch           <= '0;
          state        <= RD_I;
          bus.rd_getI  <= 1'b1;
`ifdef RX_SCHED_TICKS_EN
          tick_lat <= tick_cnt;
          tidx     <= '0;
          if (count_o == '0) begin
            state       <= TICKS;
            bus.rd_getI <= 1'b0;
          end
`endif
        end
`ifdef RX_SCHED_TICKS_EN
        TICKS: begin
          tidx <= tidx + 2'd1;
          if (tidx == 2'd2) begin
            state       <= RD_I;
            bus.rd_getI <= 1'b1;
          end
        end
`endif
        RD_I: begin
          state       <= RD_Q;
          bus.rd_getI <= 1'b0;
          bus.rd_getQ <= 1'b1;
        end
        RD_Q: begin
          state       <= RD_P;
          bus.rd_getQ <= 1'b0;
        end
        RD_P: begin
          if (ch == 4'(NRX - 1)) begin
            state        <= DONE;
            ch           <= '0;
            bus.rxn_o    <= '0;
            bus.rd_getWB <= 1'b0;
          end else begin
            state       <= RD_I;
            ch          <= ch + 4'd1;
            bus.rxn_o   <= ch + 4'd1;
            bus.rd_getI <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          if (count_o == 16'(NSAMPS - 1)) begin
            count_o    <= '0;
            offset     <= '0;
            buf_half_o <= ~buf_half_o;
            buf_ready  <= 1'b1;
          end else begin
            count_o <= count_o + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_readout_sched.sv
// tb/tb_rx_readout_sched.sv - randomized self-checking bench for rx_readout_sched against a per-cycle expectation model
`timescale 1ns/1ps
module tb_rx_readout_sched;
  localparam int NRX    = 4;
  localparam int NSAMPS = 2;
  localparam int ADDR_W = 13;
`ifdef RX_SCHED_TICKS_EN
  localparam int TW = 3;
`else
  localparam int TW = 0;
`endif
  localparam int HALF = 3 * NRX * NSAMPS + TW;
  localparam int SEQ  = 3 * NRX;
  localparam int VW   = 1 + ADDR_W + 16 + 4 + 3 + 16 + 3;
  localparam int NCYC = 8192;

  logic        adc_clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_avail_A = 1'b0;
  logic        rx_avail_wb_A = 1'b0;
  logic        wb_en = 1'b0;
  logic        overrun_clr = 1'b0;
  logic [15:0] count_o;
  logic        buf_half_o;
  logic        buf_ready;
  logic        overrun;

  rx_readout_sched_if #(.ADDR_W(ADDR_W)) bus ();

  rx_readout_sched #(.NRX(NRX), .NSAMPS(NSAMPS), .ADDR_W(ADDR_W)) dut (
    .adc_clk       (adc_clk),
    .reset         (reset),
    .rx_avail_A    (rx_avail_A),
    .rx_avail_wb_A (rx_avail_wb_A),
    .wb_en         (wb_en),
    .overrun_clr   (overrun_clr),
    .bus           (bus),
    .count_o       (count_o),
    .buf_half_o    (buf_half_o),
    .buf_ready     (buf_ready),
    .overrun       (overrun)
  );

  always #5 adc_clk = ~adc_clk;

  // Expected outputs per cycle, filled in when a sequence is accepted.
  bit              e_wr      [NCYC];
  bit [ADDR_W-1:0] e_addr    [NCYC];
  bit              e_from_din[NCYC];
  bit [15:0]       e_word    [NCYC];
  bit [6:0]        e_rd      [NCYC];
  bit              e_rdy     [NCYC];
  bit [15:0]       din_hist  [NCYC];

  int cyc = 0, next_free = 0, pend_cyc = -1, rst_cyc = 0, m_count = 0, pend_count = 0;
  bit m_half = 1'b0, pend_half = 1'b0, m_ov = 1'b0;
  logic [VW-1:0] exp_vec;
  int checks = 0, errors = 0;

  function automatic logic [VW-1:0] observe();
    logic [ADDR_W-1:0] a;
    logic [15:0]       d;
    a = bus.wr_en ? bus.waddr_o : {ADDR_W{1'b0}};
    d = bus.wr_en ? bus.wdata_o : 16'h0;
    return {bus.wr_en, a, d, bus.rxn_o, bus.rd_getI, bus.rd_getQ, bus.rd_getWB,
            count_o, buf_half_o, buf_ready, overrun};
  endfunction

  // Drive one cycle of inputs, update the model, and advance to the next cycle.
  task automatic step(input bit sa, input bit swb, input bit wb, input bit clr, input bit rst);
    bit [15:0] din, d;
    bit        pace, ov_set, tk;
    int        len, off0, base, r, j;
    bit [47:0] tv;
    din = 16'($urandom);
    din_hist[cyc] = din;
    rx_avail_A = sa; rx_avail_wb_A = swb; wb_en = wb; overrun_clr = clr; reset = rst;
    bus.rx_din = din;
    if (rst) begin
      for (int i = cyc + 1; i < cyc + 64 && i < NCYC; i++) begin
        e_wr[i] = 1'b0; e_rd[i] = '0; e_rdy[i] = 1'b0;
      end
      m_count = 0; m_half = 1'b0; m_ov = 1'b0;
      next_free = cyc + 1; pend_cyc = -1; rst_cyc = cyc;
    end else begin
      pace   = wb ? swb : sa;
      ov_set = pace && (cyc < next_free);
      if (pace && !ov_set) begin
        tk   = (TW != 0) && (m_count == 0);
        len  = SEQ + (tk ? 3 : 0);
        off0 = (m_count == 0) ? 0 : TW + SEQ * m_count;
        base = m_half ? HALF : 0;
        tv   = 48'(cyc - rst_cyc - 1);
        for (int k = 0; k < len; k++) begin
          r = cyc + 1 + k;
          if (tk && k < 3) begin
            e_rd[r] = {4'd0, 1'b0, 1'b0, wb};
            e_from_din[r+1] = 1'b0;
            e_word[r+1] = tv[16*k +: 16];
          end else begin
            j = k - (tk ? 3 : 0);
            e_rd[r] = {4'(j / 3), (j % 3) == 0, (j % 3) == 1, wb};
            e_from_din[r+1] = 1'b1;
          end
          e_wr[r+1]   = 1'b1;
          e_addr[r+1] = ADDR_W'(base + off0 + k);
        end
        pend_cyc  = cyc + len + 2;
        next_free = pend_cyc;
        if (m_count + 1 == NSAMPS) begin
          pend_count = 0; pend_half = ~m_half; e_rdy[pend_cyc] = 1'b1;
        end else begin
          pend_count = m_count + 1; pend_half = m_half;
        end
      end
      m_ov = ov_set ? 1'b1 : (clr ? 1'b0 : m_ov);
    end
    @(posedge adc_clk);
    @(negedge adc_clk);
    cyc++;
    if (cyc == pend_cyc) begin
      m_count = pend_count; m_half = pend_half;
    end
    d = e_from_din[cyc] ? din_hist[cyc-1] : e_word[cyc];
    exp_vec = {e_wr[cyc], e_wr[cyc] ? e_addr[cyc] : {ADDR_W{1'b0}}, e_wr[cyc] ? d : 16'h0,
               e_rd[cyc], 16'(m_count), m_half, e_rdy[cyc], m_ov};
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1);
      checks++;
      if (observe() !== exp_vec) begin
        errors++; $display("FAIL reset_vec cyc=%0d got=%h exp=%h", cyc, observe(), exp_vec);
      end
    end
    checks++;
    if ({bus.waddr_o, bus.wdata_o} !== '0) begin
      errors++; $display("FAIL reset_bus got=%h/%h exp=0/0", bus.waddr_o, bus.wdata_o);
    end
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_basic();
    int t0, nwr = 0, first = -1, first_addr = -1;
    while (cyc < 10) step(0, 0, 0, 0, 0);
    t0 = cyc;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (observe() !== exp_vec) begin
        errors++; $display("FAIL basic_vec cyc=%0d got=%h exp=%h", cyc, observe(), exp_vec);
      end
      if (bus.wr_en === 1'b1) begin
        if (nwr == 0) begin first = cyc; first_addr = int'(bus.waddr_o); end
        nwr++;
      end
      step(0, 0, 0, 0, 0);
    end
    checks++;
    if (nwr != SEQ + TW || first != t0 + 2 || first_addr != 0) begin
      errors++;
      $display("FAIL basic_writes got=%0d@%0d addr %0d exp=%0d@%0d addr 0", nwr, first, first_addr, SEQ + TW, t0 + 2);
    end
  endtask

  task automatic test_swap();
    int seen_rdy = 0, a3 = -1;
    for (int s = 0; s < 2; s++) begin
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 19; i++) begin
        checks++;
        if (observe() !== exp_vec) begin
          errors++; $display("FAIL swap_vec cyc=%0d got=%h exp=%h", cyc, observe(), exp_vec);
        end
        if (buf_ready === 1'b1) seen_rdy++;
        if (s == 1 && bus.wr_en === 1'b1 && a3 < 0) a3 = int'(bus.waddr_o);
        step(0, 0, 0, 0, 0);
      end
    end
    checks++;
    if (seen_rdy != 1 || a3 != HALF) begin
      errors++; $display("FAIL swap_half got rdy=%0d addr=%0d exp rdy=1 addr=%0d", seen_rdy, a3, HALF);
    end
  endtask

  task automatic test_overrun();
    int nwr = 0;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 22; i++) begin
      checks++;
      if (observe() !== exp_vec) begin
        errors++; $display("FAIL ovr_vec cyc=%0d got=%h exp=%h", cyc, observe(), exp_vec);
      end
      if (bus.wr_en === 1'b1) nwr++;
      step(i == 3, 0, 0, i == 10, 0);
    end
    checks++;
    if (nwr != SEQ + TW || overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_writes got=%0d ov=%b exp=%0d ov=0", nwr, overrun, SEQ + TW);
    end
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    checks++;
    if (overrun !== 1'b1 || observe() !== exp_vec) begin
      errors++; $display("FAIL ovr_setwins got=%b exp=1", overrun);
    end
    for (int i = 0; i < 14; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    checks++;
    if (overrun !== 1'b0 || observe() !== exp_vec) begin
      errors++; $display("FAIL ovr_clear got=%b exp=0", overrun);
    end
  endtask

  task automatic test_back_to_back();
    int len;
    len = SEQ + ((TW != 0 && m_count == 0) ? 3 : 0);
    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= len + 1; i++) step(i == len + 1, 0, 0, 0, 0);
    checks++;
    if (overrun !== 1'b1 || observe() !== exp_vec) begin
      errors++; $display("FAIL b2b_done_strobe got ov=%b exp=1", overrun);
    end
    for (int i = 0; i < 2 * SEQ + 8; i++) begin
      step(i == 0, 0, 0, i == 0, 0);
      checks++;
      if (observe() !== exp_vec) begin
        errors++; $display("FAIL b2b_vec cyc=%0d got=%h exp=%h", cyc, observe(), exp_vec);
      end
    end
  endtask

  task automatic test_wideband();
    int nwb = 0;
    for (int i = 0; i < 4; i++) step(i == 1, 0, 1, 0, 0);
    checks++;
    if (bus.rd_getI !== 1'b0 || observe() !== exp_vec) begin
      errors++; $display("FAIL wb_ignore_A got getI=%b exp=0", bus.rd_getI);
    end
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < SEQ + 8; i++) begin
      checks++;
      if (observe() !== exp_vec) begin
        errors++; $display("FAIL wb_vec cyc=%0d got=%h exp=%h", cyc, observe(), exp_vec);
      end
      if (bus.rd_getWB === 1'b1) nwb++;
      step(0, 0, i < 4, 0, 0);
    end
    checks++;
    if (nwb != SEQ + ((TW != 0) ? 3 : 0) * int'(m_count == 0 && m_half == 1'b0 && 1'b0)) begin
      errors++; $display("FAIL wb_hold got=%0d exp=%0d", nwb, SEQ);
    end
  endtask

  task automatic test_reset_mid();
    int a0 = -1, r0 = -1, nwr = 0;
    step(1, 0, 0, 0, 0);
    for (int i = 1; i < 5; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    checks++;
    if (observe() !== '0 || {bus.waddr_o, bus.wdata_o} !== '0) begin
      errors++; $display("FAIL rstmid_zero got=%h exp=0", observe());
    end
    for (int i = 0; i < 6; i++) begin
      if (bus.wr_en === 1'b1) nwr++;
      step(0, 0, 0, 0, 0);
    end
    checks++;
    if (nwr != 0) begin
      errors++; $display("FAIL rstmid_nowr got=%0d exp=0", nwr);
    end
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < SEQ + 8; i++) begin
      checks++;
      if (observe() !== exp_vec) begin
        errors++; $display("FAIL rstmid_vec cyc=%0d got=%h exp=%h", cyc, observe(), exp_vec);
      end
      if (bus.wr_en === 1'b1 && a0 < 0) a0 = int'(bus.waddr_o);
      if (bus.rd_getI === 1'b1 && r0 < 0) r0 = int'(bus.rxn_o);
      step(0, 0, 0, 0, 0);
    end
    checks++;
    if (a0 != 0 || r0 != 0) begin
      errors++; $display("FAIL rstmid_restart got addr=%0d ch=%0d exp 0/0", a0, r0);
    end
  endtask

`ifdef RX_SCHED_TICKS_EN
  task automatic test_ticks();
    int nw = 0, a_samp = -1, a2 = -1;
    bit [15:0] w[3];
    step(0, 0, 0, 0, 1);
    while (cyc - rst_cyc - 1 < 100) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < SEQ + 8; i++) begin
      checks++;
      if (observe() !== exp_vec) begin
        errors++; $display("FAIL ticks_vec cyc=%0d got=%h exp=%h", cyc, observe(), exp_vec);
      end
      if (bus.wr_en === 1'b1) begin
        if (nw < 3) w[nw] = bus.wdata_o;
        if (nw == 3) a_samp = int'(bus.waddr_o);
        nw++;
      end
      step(0, 0, 0, 0, 0);
    end
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < SEQ + 4; i++) begin
      if (bus.wr_en === 1'b1 && a2 < 0) a2 = int'(bus.waddr_o);
      step(0, 0, 0, 0, 0);
    end
    checks++;
    if (w[0] != 16'd100 || w[1] != 16'd0 || w[2] != 16'd0 || a_samp != 3 || a2 != 3 + SEQ) begin
      errors++;
      $display("FAIL ticks_words got=%0d,%0d,%0d a=%0d a2=%0d exp=100,0,0 a=3 a2=%0d", w[0], w[1], w[2], a_samp, a2, 3 + SEQ);
    end
  endtask
`endif

  task automatic test_random();
    bit wb, p, o;
    for (int i = 0; i < 900; i++) begin
      wb = ((i / 300) % 2) == 1;
      p  = $urandom_range(0, 7) == 0;
      o  = $urandom_range(0, 15) == 0;
      step(wb ? o : p, wb ? p : o, wb, $urandom_range(0, 19) == 0, 0);
      checks++;
      if (observe() !== exp_vec) begin
        errors++; $display("FAIL random_vec cyc=%0d got=%h exp=%h", cyc, observe(), exp_vec);
      end
    end
  endtask

  initial begin
    bus.rx_din = 16'h0;
    test_reset();
    test_basic();
    test_swap();
    test_overrun();
    test_back_to_back();
    test_wideband();
    test_reset_mid();
`ifdef RX_SCHED_TICKS_EN
    test_ticks();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
